// File: rtl/fib_pkg.sv
// Types and constants shared by the FIB table, the PIT and the hash-unit arbiter.
package fib_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int HASH_W   = 10;

  typedef struct packed {
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
  } fib_req_t;

  // Round-robin successor of requester idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set req bit at or above ptr, with
// wrap, receives the one-hot grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int PW = $clog2(N);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fib_hash_arbiter.sv
// Shares the prefix hash unit between FIB requesters: round-robin grant, registered
// hash inputs, and a tag pipeline that routes each hash back to its issuer.
module fib_hash_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int PREFIX_W = fib_pkg::PREFIX_W,
  parameter int LEN_W    = fib_pkg::LEN_W,
  parameter int HASH_W   = fib_pkg::HASH_W,
  parameter int HASH_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*PREFIX_W-1:0] req_prefix,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [HASH_W-1:0]           rsp_hash,
  output logic [PREFIX_W-1:0]         hash_prefix_in,
  output logic [LEN_W-1:0]            hash_len_in,
  input  logic [HASH_W-1:0]           hash
);

  import fib_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_next;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] outstanding;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_set;
  logic               accept;
  logic [HASH_LAT-1:0] pipe_valid;
  logic [PW-1:0]       pipe_tag [HASH_LAT];

  assign eligible = req_valid & ~outstanding;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign req_ready = rst ? '0 : gnt;
  assign accept    = |req_ready;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_idx = PW'(i);
  end

  assign ptr_next = PW'(rr_next(int'(gnt_idx), NUM_REQ));

  // The oldest pipeline entry is the request whose hash is valid this cycle.
  always_comb begin
    rsp_set = '0;
    if (pipe_valid[HASH_LAT-1]) rsp_set[pipe_tag[HASH_LAT-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr         <= '0;
      outstanding    <= '0;
      rsp_valid      <= '0;
      rsp_hash       <= '0;
      hash_prefix_in <= '0;
      hash_len_in    <= '0;
      pipe_valid     <= '0;
      for (int i = 0; i < HASH_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      outstanding <= (outstanding & ~rsp_set) | req_ready;
      rsp_valid   <= rsp_set;
      if (pipe_valid[HASH_LAT-1]) rsp_hash <= hash;

      pipe_valid[0] <= accept;
      pipe_tag[0]   <= gnt_idx;
      for (int i = 1; i < HASH_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end

      if (accept) begin
        hash_prefix_in <= req_prefix[gnt_idx*PREFIX_W +: PREFIX_W];
        hash_len_in    <= req_len[gnt_idx*LEN_W +: LEN_W];
        rr_ptr         <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_fib_hash_arbiter.sv
// Directed bench: three arbiter configurations (2 req / lat 1, 2 req / lat 3,
// 4 req / lat 1), each driven by its own behavioural hash unit.
module tb_fib_hash_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2 requesters, HASH_LAT=1
  logic         rst_l1;
  logic [1:0]   l1_req_valid, l1_req_ready, l1_rsp_valid;
  logic [127:0] l1_req_prefix;
  logic [11:0]  l1_req_len;
  logic [9:0]   l1_rsp_hash, l1_hash;
  logic [63:0]  l1_hpi;
  logic [5:0]   l1_hli;

  // 2 requesters, HASH_LAT=3
  logic         rst_l3;
  logic [1:0]   l3_req_valid, l3_req_ready, l3_rsp_valid;
  logic [127:0] l3_req_prefix;
  logic [11:0]  l3_req_len;
  logic [9:0]   l3_rsp_hash, l3_hash, l3_d1, l3_d2;
  logic [63:0]  l3_hpi;
  logic [5:0]   l3_hli;

  // 4 requesters, HASH_LAT=1
  logic         rst_n4;
  logic [3:0]   n4_req_valid, n4_req_ready, n4_rsp_valid;
  logic [255:0] n4_req_prefix;
  logic [23:0]  n4_req_len;
  logic [9:0]   n4_rsp_hash, n4_hash;
  logic [63:0]  n4_hpi;
  logic [5:0]   n4_hli;

  function automatic logic [9:0] hmodel(input logic [63:0] p, input logic [5:0] l);
    if (p == 64'h0000_0000_DEAD_BEEF) return 10'h1A5;
    return p[9:0] ^ p[19:10] ^ p[29:20] ^ p[39:30] ^ p[49:40] ^ p[59:50]
         ^ {6'b0, p[63:60]} ^ {4'b0, l};
  endfunction

  assign l1_hash = hmodel(l1_hpi, l1_hli);
  assign n4_hash = hmodel(n4_hpi, n4_hli);

  always_ff @(posedge clk) begin
    l3_d1 <= hmodel(l3_hpi, l3_hli);
    l3_d2 <= l3_d1;
  end
  assign l3_hash = l3_d2;

  fib_hash_arbiter #(.NUM_REQ(2), .HASH_LAT(1)) u_l1 (
    .clk(clk), .rst(rst_l1), .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_prefix(l1_req_prefix), .req_len(l1_req_len), .rsp_valid(l1_rsp_valid),
    .rsp_hash(l1_rsp_hash), .hash_prefix_in(l1_hpi), .hash_len_in(l1_hli), .hash(l1_hash));

  fib_hash_arbiter #(.NUM_REQ(2), .HASH_LAT(3)) u_l3 (
    .clk(clk), .rst(rst_l3), .req_valid(l3_req_valid), .req_ready(l3_req_ready),
    .req_prefix(l3_req_prefix), .req_len(l3_req_len), .rsp_valid(l3_rsp_valid),
    .rsp_hash(l3_rsp_hash), .hash_prefix_in(l3_hpi), .hash_len_in(l3_hli), .hash(l3_hash));

  fib_hash_arbiter #(.NUM_REQ(4), .HASH_LAT(1)) u_n4 (
    .clk(clk), .rst(rst_n4), .req_valid(n4_req_valid), .req_ready(n4_req_ready),
    .req_prefix(n4_req_prefix), .req_len(n4_req_len), .rsp_valid(n4_rsp_valid),
    .rsp_hash(n4_rsp_hash), .hash_prefix_in(n4_hpi), .hash_len_in(n4_hli), .hash(n4_hash));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  localparam logic [63:0] P0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] P1 = 64'hAAAA_5555_0F0F_F0F0;
  localparam logic [63:0] PF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] Q3 = 64'hFEDC_BA98_7654_3210;

  initial begin
    logic [1:0] e2;
    rst_l1 = 1'b1; rst_l3 = 1'b1; rst_n4 = 1'b1;
    l1_req_valid = 2'b11; l1_req_prefix = '0; l1_req_len = '0;
    l3_req_valid = 2'b00; l3_req_prefix = '0; l3_req_len = '0;
    n4_req_valid = 4'b0000; n4_req_prefix = '0; n4_req_len = '0;
    repeat (3) step();

    // reset state, with requests pending during reset
    samp();
    chk("rst_ready_l1", l1_req_ready, 0);
    chk("rst_rsp_valid", l1_rsp_valid, 0);
    chk("rst_rsp_hash", l1_rsp_hash, 0);
    chk("rst_hpi", l1_hpi, 0);
    chk("rst_hli", l1_hli, 0);
    chk("rst_ready_l3", l3_req_ready, 0);
    chk("rst_ready_n4", n4_req_ready, 0);
    step();
    rst_l1 = 1'b0; rst_l3 = 1'b0; rst_n4 = 1'b0; l1_req_valid = 2'b00;

    // single request, latency 1
    step();
    l1_req_valid = 2'b01; l1_req_prefix[63:0] = 64'h0000_0000_DEAD_BEEF; l1_req_len[5:0] = 6'd32;
    samp(); chk("s1_ready", l1_req_ready, 2'b01);
    step(); l1_req_valid = 2'b00;
    samp();
    chk("s1_hpi", l1_hpi, 64'h0000_0000_DEAD_BEEF);
    chk("s1_hli", l1_hli, 32);
    chk("s1_rsp_early", l1_rsp_valid, 0);
    step(); samp();
    chk("s1_rsp_valid", l1_rsp_valid, 2'b01);
    chk("s1_rsp_hash", l1_rsp_hash, 10'h1A5);
    step(); samp();
    chk("s1_rsp_pulse", l1_rsp_valid, 0);

    // contention, latency 1
    step(); rst_l1 = 1'b1; step(); rst_l1 = 1'b0;
    l1_req_prefix = {P1, P0}; l1_req_len = {6'd24, 6'd8}; l1_req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      samp();
      e2 = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("c1_ready_%0d", k), l1_req_ready, e2);
      if (k >= 2) begin
        chk($sformatf("c1_rsp_valid_%0d", k), l1_rsp_valid, e2);
        chk($sformatf("c1_rsp_hash_%0d", k), l1_rsp_hash,
            (k % 2 == 0) ? hmodel(P0, 6'd8) : hmodel(P1, 6'd24));
      end
      step();
    end
    l1_req_valid = 2'b00;

    // reset one cycle after an accept
    step(); rst_l1 = 1'b1; step(); rst_l1 = 1'b0;
    l1_req_valid = 2'b01;
    samp(); chk("mf_pre_ready", l1_req_ready, 2'b01);
    step(); l1_req_valid = 2'b00;
    step(); step();
    l1_req_valid = 2'b11;
    samp(); chk("mf_ready_ptr1", l1_req_ready, 2'b10);
    step(); rst_l1 = 1'b1;
    samp(); chk("mf_ready_in_rst", l1_req_ready, 0);
    step(); rst_l1 = 1'b0;
    samp();
    chk("mf_rsp_valid", l1_rsp_valid, 0);
    chk("mf_rsp_hash", l1_rsp_hash, 0);
    chk("mf_hpi", l1_hpi, 0);
    chk("mf_hli", l1_hli, 0);
    chk("mf_first_grant", l1_req_ready, 2'b01);
    step(); l1_req_valid = 2'b00;
    samp();
    chk("mf_rsp_dropped", l1_rsp_valid, 0);
    chk("mf_post_hpi", l1_hpi, P0);
    step();

    // boundary payloads
    l1_req_prefix[63:0] = '0; l1_req_len[5:0] = 6'd0; l1_req_valid = 2'b01;
    samp(); chk("bd_ready0", l1_req_ready, 2'b01);
    step();
    l1_req_prefix[127:64] = PF; l1_req_len[11:6] = 6'd63; l1_req_valid = 2'b10;
    samp();
    chk("bd_hpi0", l1_hpi, 0);
    chk("bd_hli0", l1_hli, 0);
    chk("bd_ready1", l1_req_ready, 2'b10);
    step(); l1_req_valid = 2'b00;
    samp();
    chk("bd_hpi1", l1_hpi, PF);
    chk("bd_hli1", l1_hli, 63);
    chk("bd_rsp_valid0", l1_rsp_valid, 2'b01);
    chk("bd_rsp_hash0", l1_rsp_hash, hmodel(64'h0, 6'd0));
    step(); samp();
    chk("bd_rsp_valid1", l1_rsp_valid, 2'b10);
    chk("bd_rsp_hash1", l1_rsp_hash, hmodel(PF, 6'd63));

    // outstanding blocking, latency 3
    step();
    l3_req_prefix = {P1, P0}; l3_req_len = {6'd24, 6'd8}; l3_req_valid = 2'b01;
    for (int k = 0; k < 9; k++) begin
      samp();
      chk($sformatf("ob_ready_%0d", k), l3_req_ready, (k % 4 == 0) ? 2'b01 : 2'b00);
      chk($sformatf("ob_rsp_%0d", k), l3_rsp_valid, (k >= 4 && k % 4 == 0) ? 2'b01 : 2'b00);
      if (k >= 4 && k % 4 == 0) chk($sformatf("ob_hash_%0d", k), l3_rsp_hash, hmodel(P0, 6'd8));
      step();
    end
    l3_req_valid = 2'b00;
    repeat (4) step();
    rst_l3 = 1'b1; step(); rst_l3 = 1'b0;

    // contention, latency 3
    l3_req_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      samp();
      e2 = (k % 4 == 0) ? 2'b01 : (k % 4 == 1) ? 2'b10 : 2'b00;
      chk($sformatf("c3_ready_%0d", k), l3_req_ready, e2);
      if (k >= 4) begin
        chk($sformatf("c3_rsp_%0d", k), l3_rsp_valid, e2);
        if (e2 != 2'b00)
          chk($sformatf("c3_hash_%0d", k), l3_rsp_hash,
              (k % 4 == 0) ? hmodel(P0, 6'd8) : hmodel(P1, 6'd24));
      end
      step();
    end
    l3_req_valid = 2'b00;

    // four requesters: move rr_ptr to 2, then contend 1 vs 3
    n4_req_prefix[64 +: 64] = Q1; n4_req_len[6 +: 6] = 6'd5;
    n4_req_prefix[192 +: 64] = Q3; n4_req_len[18 +: 6] = 6'd17;
    n4_req_valid = 4'b0010;
    samp(); chk("n4_setup", n4_req_ready, 4'b0010);
    step(); n4_req_valid = 4'b0000;
    step(); step();
    n4_req_valid = 4'b1010;
    samp(); chk("n4_g3_first", n4_req_ready, 4'b1000);
    step(); samp(); chk("n4_g1", n4_req_ready, 4'b0010);
    step(); samp();
    chk("n4_g3_second", n4_req_ready, 4'b1000);
    chk("n4_rsp_valid", n4_rsp_valid, 4'b1000);
    chk("n4_rsp_hash", n4_rsp_hash, hmodel(Q3, 6'd17));
    step(); n4_req_valid = 4'b0000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
